// File: rtl/ex_stage_unit.sv
// ex_stage_unit -- registered EX stage for the 64-bit LEGv8-style pipeline.
//
// Decodes the ALU operation from ALUOp and instruction bits [31:21] and picks
// operand B (register or sign-extended immediate). It computes the ALU result,
// the zero flag, the branch target (old_pc + imm*4) and pc+4. All five results
// are captured in one output register, which forms the EX->MEM boundary.
//
// Ports:
//   clock, reset              rising-edge clock; synchronous active-high reset
//   alu_op_1, alu_op_0        ALUOp from main control
//   instruction_part[10:0]    instruction bits [31:21] (R-type opcode)
//   alu_src                   0: B = reg_data_2, 1: B = sign_extend
//   reg_data_1/2, sign_extend operands (WIDTH)
//   old_pc                    PC of the instruction in EX
//   operation_code[3:0]       registered ALU control code
//   alu_result, zero          registered ALU result and its all-zero flag
//   branch_target, pc_plus_4  registered adder outputs

// Plain modulo-2^WIDTH adder. There is no carry in and no carry out.
module ex_stage_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

module ex_stage_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_op_1,
  input  logic             alu_op_0,
  input  logic [10:0]      instruction_part,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] reg_data_1,
  input  logic [WIDTH-1:0] reg_data_2,
  input  logic [WIDTH-1:0] sign_extend,
  input  logic [WIDTH-1:0] old_pc,
  output logic [3:0]       operation_code,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc_plus_4
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_PSB = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [3:0]       op_c;
  logic [WIDTH-1:0] opb, res_c, br_off, br_sum, pc4_sum;

  // ALU control. ALUOp=1x defers to the R-type opcode field. Unknown opcodes
  // fall back to ADD.
  always_comb begin
    op_c = OP_ADD;
    if (alu_op_1) begin
      case (instruction_part)
        11'b10001011000: op_c = OP_ADD;
        11'b11001011000: op_c = OP_SUB;
        11'b10001010000: op_c = OP_AND;
        11'b10101010000: op_c = OP_ORR;
        default:         op_c = OP_ADD;
      endcase
    end else if (alu_op_0) begin
      op_c = OP_PSB;
    end
  end

  assign opb = alu_src ? sign_extend : reg_data_2;

  always_comb begin
    res_c = '0;
    case (op_c)
      OP_AND:  res_c = reg_data_1 & opb;
      OP_ORR:  res_c = reg_data_1 | opb;
      OP_ADD:  res_c = reg_data_1 + opb;
      OP_SUB:  res_c = reg_data_1 - opb;
      OP_PSB:  res_c = opb;
      OP_NOR:  res_c = ~(reg_data_1 | opb);
      default: res_c = '0;
    endcase
  end

  // Word offset: the top two bits of the immediate fall off the shift.
  assign br_off = {sign_extend[WIDTH-3:0], 2'b00};

  ex_stage_adder #(.WIDTH(WIDTH)) u_br_add  (.a(old_pc), .b(br_off),  .sum(br_sum));
  ex_stage_adder #(.WIDTH(WIDTH)) u_pc4_add (.a(old_pc), .b(PC_STEP), .sum(pc4_sum));

  always_ff @(posedge clock) begin
    if (reset) begin
      operation_code <= '0;
      alu_result     <= '0;
      zero           <= 1'b0;
      branch_target  <= '0;
      pc_plus_4      <= '0;
    end else begin
      operation_code <= op_c;
      alu_result     <= res_c;
      zero           <= (res_c == '0);
      branch_target  <= br_sum;
      pc_plus_4      <= pc4_sum;
    end
  end
endmodule

// File: tb/tb_ex_stage_unit.sv
module tb_ex_stage_unit;
  localparam int W = 64;
  localparam logic [10:0] I_ADD = 11'b10001011000;
  localparam logic [10:0] I_SUB = 11'b11001011000;
  localparam logic [10:0] I_AND = 11'b10001010000;
  localparam logic [10:0] I_ORR = 11'b10101010000;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clock = 1'b0;
  logic reset;
  logic alu_op_1, alu_op_0, alu_src;
  logic [10:0] instruction_part;
  logic [W-1:0] reg_data_1, reg_data_2, sign_extend, old_pc;
  logic [3:0] operation_code;
  logic [W-1:0] alu_result, branch_target, pc_plus_4;
  logic zero;

  int checks = 0;
  int errors = 0;

  logic [3:0]   e_code;
  logic [W-1:0] e_res, e_br, e_pc4;
  logic         e_zero;

  always #5 clock = ~clock;

  ex_stage_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .alu_op_1(alu_op_1), .alu_op_0(alu_op_0),
    .instruction_part(instruction_part), .alu_src(alu_src),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .sign_extend(sign_extend),
    .old_pc(old_pc), .operation_code(operation_code), .alu_result(alu_result),
    .zero(zero), .branch_target(branch_target), .pc_plus_4(pc_plus_4)
  );

  // Reference model: the ALU control table and the arithmetic rules.
  function automatic logic [3:0] m_code(input logic a1, input logic a0, input logic [10:0] ip);
    if (!a1) return a0 ? 4'd7 : 4'd2;
    if (ip == I_SUB) return 4'd6;
    if (ip == I_AND) return 4'd0;
    if (ip == I_ORR) return 4'd1;
    return 4'd2;
  endfunction

  function automatic logic [W-1:0] m_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return b;
      4'd12: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: the model captures what the edge must produce, then the outputs
  // are compared on the falling edge.
  task automatic cycle();
    logic [W-1:0] b;
    @(posedge clock);
    b = alu_src ? sign_extend : reg_data_2;
    if (reset) begin
      e_code = 0; e_res = 0; e_zero = 0; e_br = 0; e_pc4 = 0;
    end else begin
      e_code = m_code(alu_op_1, alu_op_0, instruction_part);
      e_res  = m_alu(e_code, reg_data_1, b);
      e_zero = (e_res == 0);
      e_br   = old_pc + sign_extend * 4;
      e_pc4  = old_pc + 4;
    end
    @(negedge clock);
    chk("operation_code", W'(operation_code), W'(e_code));
    chk("alu_result", alu_result, e_res);
    chk("zero", W'(zero), W'(e_zero));
    chk("branch_target", branch_target, e_br);
    chk("pc_plus_4", pc_plus_4, e_pc4);
  endtask

  task automatic drive(input logic [1:0] aop, input logic [10:0] ip, input logic src,
                       input logic [W-1:0] a, input logic [W-1:0] b2,
                       input logic [W-1:0] se, input logic [W-1:0] pc);
    {alu_op_1, alu_op_0} = aop;
    instruction_part = ip; alu_src = src;
    reg_data_1 = a; reg_data_2 = b2; sign_extend = se; old_pc = pc;
  endtask

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = ONES;
      2: v = W'($urandom_range(0, 15));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    drive(2'b10, I_SUB, 1'b0, 64'h1234, 64'h55, 64'h7, 64'h1000);
    cycle();
    drive(2'b01, I_AND, 1'b1, ONES, 64'h1, 64'h9, 64'h2000);
    cycle();
    chk("rst_code", W'(operation_code), 64'd0);
    chk("rst_res", alu_result, 64'd0);
    chk("rst_zero", W'(zero), 64'd0);
    chk("rst_pc4", pc_plus_4, 64'd0);

    reset = 1'b0;
    drive(2'b10, I_ADD, 1'b0, 64'd12, 64'd10, 64'd3, 64'h40);
    cycle();
    chk("add_lit", alu_result, 64'd22);
    chk("add_code", W'(operation_code), 64'd2);
    chk("br_lit", branch_target, 64'h4C);
    chk("pc4_lit", pc_plus_4, 64'h44);

    drive(2'b10, I_SUB, 1'b0, 64'd12, 64'd10, ONES - 1, 64'h40);
    cycle();
    chk("sub_lit", alu_result, 64'd2);
    chk("sub_code", W'(operation_code), 64'd6);
    chk("br_back_lit", branch_target, 64'h38);

    drive(2'b10, I_AND, 1'b0, 64'd12, 64'd10, 64'd0, 64'h0);
    cycle();
    chk("and_lit", alu_result, 64'd8);
    chk("and_code", W'(operation_code), 64'd0);

    drive(2'b10, I_ORR, 1'b0, 64'd12, 64'd10, 64'd0, 64'h0);
    cycle();
    chk("orr_lit", alu_result, 64'd14);
    chk("orr_code", W'(operation_code), 64'd1);

    drive(2'b10, I_SUB, 1'b0, 64'd5, 64'd5, 64'd0, 64'h0);
    cycle();
    chk("sub_eq_res", alu_result, 64'd0);
    chk("sub_eq_zero", W'(zero), 64'd1);

    drive(2'b00, I_SUB, 1'b1, 64'h100, 64'd77, 64'd8, 64'h0);
    cycle();
    chk("ld_lit", alu_result, 64'h108);
    chk("ld_code", W'(operation_code), 64'd2);

    drive(2'b11, 11'b11111111111, 1'b0, 64'd3, 64'd4, 64'd0, 64'h0);
    cycle();
    chk("undef_add", alu_result, 64'd7);
    chk("undef_code", W'(operation_code), 64'd2);

    drive(2'b01, I_SUB, 1'b0, 64'd99, 64'd0, 64'd0, 64'h0);
    cycle();
    chk("cbz0_code", W'(operation_code), 64'd7);
    chk("cbz0_zero", W'(zero), 64'd1);

    drive(2'b01, I_SUB, 1'b0, 64'd99, 64'd7, 64'd0, 64'h0);
    cycle();
    chk("cbz7_res", alu_result, 64'd7);
    chk("cbz7_zero", W'(zero), 64'd0);

    drive(2'b10, I_ADD, 1'b0, ONES, 64'd1, 64'd0, ONES - 3);
    cycle();
    chk("wrap_add", alu_result, 64'd0);
    chk("wrap_zero", W'(zero), 64'd1);
    chk("wrap_pc4", pc_plus_4, 64'd0);

    drive(2'b10, I_SUB, 1'b0, 64'd0, 64'd1, 64'd0, 64'h0);
    cycle();
    chk("wrap_sub", alu_result, ONES);
    chk("wrap_sub_zero", W'(zero), 64'd0);

    // Random back-to-back traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      logic [10:0] ip;
      case ($urandom_range(0, 4))
        0: ip = I_ADD;
        1: ip = I_SUB;
        2: ip = I_AND;
        3: ip = I_ORR;
        default: ip = 11'($urandom);
      endcase
      reset = ($urandom_range(0, 19) == 0);
      drive(2'($urandom), ip, 1'($urandom), rnd64(), rnd64(), rnd64(), rnd64());
      if ($urandom_range(0, 7) == 0) reg_data_2 = reg_data_1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
